// File: rtl/sled_scan.sv
// Multiplexed N-digit hex 7-segment driver with blanking and tear-free load.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module sled_scan #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [31:0] BLANK = 32'(BLANK_CYCLES);

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] pend_data;
  logic [4*NUM_DIGITS-1:0] disp_data;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   disp_dp;
  logic                    wrap;
  logic                    boundary;
  logic                    accept;
  logic                    in_blank;
  logic                    digit_off;
  logic                    dp_sel;
  logic [3:0]              nib;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    unique case (n)
      4'h0: f = 7'h40;
      4'h1: f = 7'h79;
      4'h2: f = 7'h24;
      4'h3: f = 7'h30;
      4'h4: f = 7'h19;
      4'h5: f = 7'h12;
      4'h6: f = 7'h02;
      4'h7: f = 7'h78;
      4'h8: f = 7'h00;
      4'h9: f = 7'h10;
      4'hA: f = 7'h08;
      4'hB: f = 7'h03;
      4'hC: f = 7'h46;
      4'hD: f = 7'h21;
      4'hE: f = 7'h06;
      4'hF: f = 7'h0E;
    endcase
    return f;
  endfunction

  assign wrap       = (presc == P_LAST);
  assign boundary   = wrap && (idx == I_LAST);
  assign accept     = load_valid && !pending;
  assign load_ready = !pending;
  assign in_blank   = 32'(presc) < BLANK;

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib    = disp_data[4*i +: 4];
        dp_sel = disp_dp[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] hi;

  // hi stays 0 for an all-zero value, so digit 0 is never suppressed
  always_comb begin
    hi = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (disp_data[4*i +: 4] != 4'h0) hi = IW'(i);
    end
  end

  assign digit_off = (idx > hi);
`else
  assign digit_off = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (wrap) begin
      presc <= '0;
      idx   <= (idx == I_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // accept is only possible with pending clear, so it never races the apply
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_data <= '0;
      pend_dp   <= '0;
      disp_data <= '0;
      disp_dp   <= '0;
    end else begin
      if (boundary && pending) begin
        pending   <= 1'b0;
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end else if (accept) begin
        pending   <= 1'b1;
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      seg        <= 8'hFF;
      dig        <= '1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary && pending;
      if (in_blank) begin
        seg <= 8'hFF;
        dig <= '1;
      end else begin
        dig <= ~(NUM_DIGITS'(1) << idx);
        seg <= digit_off ? 8'hFF : {~dp_sel, font(nib)};
      end
    end
  end

endmodule

// File: tb/tb_sled_scan.sv
// Scoreboard bench for sled_scan: 4 digits, 8-cycle slots, 2 blank cycles.
// Loads are queued on accept and popped when frame_tick applies them.
module tb_sled_scan;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BC = 2;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  p;
  } ld_t;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_tick;

  ld_t sb[$];
  ld_t cur;
  bit  pend;
  int  n_cmp = 0;
  int  n_bad = 0;

  sled_scan #(
    .NUM_DIGITS(ND),
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clock(clock),
    .rst(rst),
    .data_in(data_in),
    .dp_in(dp_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .seg(seg),
    .dig(dig),
    .frame_tick(frame_tick)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input ld_t v, input int i);
    logic [7:0] s;
    s = {~v.p[i], font(v.d[4*i +: 4])};
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int k = 0; k < ND; k++)
        if (v.d[4*k +: 4] != 4'h0) hi = k;
      if (i > hi) s = 8'hFF;
    end
`endif
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    load_valid = 1'b0;
    #1;
    chk("rst/dig", dig, 4'hF);
    chk("rst/seg", seg, 8'hFF);
    chk("rst/tick", frame_tick, 1'b0);
    chk("rst/ready", load_ready, 1'b1);
    @(posedge clock);
    #1;
    rst = 1'b0;
    pend = 1'b0;
    cur = '0;
    sb.delete();
  endtask

  // Sample j follows the edge that processed slot state j of the frame.
  task automatic frame(input string nm, input int ncyc,
                       input int la, input ld_t va,
                       input int lb, input ld_t vb);
    for (int j = 0; j < ncyc; j++) begin
      logic       acc;
      logic       et;
      logic [3:0] ed;
      logic [7:0] es;
      int         p;
      int         ix;
      @(posedge clock);
      #1;
      p  = j % SD;
      ix = j / SD;
      if (p < BC) begin
        ed = 4'hF;
        es = 8'hFF;
      end else begin
        ed = ~(4'b0001 << ix);
        es = exp_seg(cur, ix);
      end
      chk($sformatf("%s/dig@%0d", nm, j), dig, ed);
      chk($sformatf("%s/seg@%0d", nm, j), seg, es);
      acc = load_valid && !pend;
      et  = (j == ND*SD-1) && pend;
      if (et) begin
        pend = 1'b0;
        if (sb.size() > 0) cur = sb.pop_front();
        else chk($sformatf("%s/sb_empty", nm), 1, 0);
      end
      if (acc) begin
        pend = 1'b1;
        sb.push_back(ld_t'({data_in, dp_in}));
      end
      chk($sformatf("%s/tick@%0d", nm, j), frame_tick, et);
      chk($sformatf("%s/ready@%0d", nm, j), load_ready, !pend);
      if (j == la) begin
        load_valid = 1'b1;
        data_in = va.d;
        dp_in = va.p;
      end else if (j == lb) begin
        load_valid = 1'b1;
        data_in = vb.d;
        dp_in = vb.p;
      end else begin
        load_valid = 1'b0;
        data_in = 16'h0000;
        dp_in = 4'h0;
      end
    end
  endtask

  localparam ld_t VA = '{d: 16'h12AF, p: 4'b0100};
  localparam ld_t VB = '{d: 16'h5555, p: 4'b0000};
  localparam ld_t VC = '{d: 16'hB3E0, p: 4'b1001};
  localparam ld_t VD = '{d: 16'h7777, p: 4'b1111};
  localparam ld_t VE = '{d: 16'h0050, p: 4'b0000};
  localparam ld_t VF = '{d: 16'h0000, p: 4'b0000};
  localparam ld_t V0 = '{d: 16'h0000, p: 4'b0000};

  initial begin
    #2;
    do_reset();
    frame("idle", ND*SD, -1, V0, -1, V0);
    frame("ld_a", ND*SD, 5, VA, 20, VB);
    frame("show_a", ND*SD, 30, VC, -1, V0);
    frame("hold_a", ND*SD, -1, V0, -1, V0);
    frame("show_c", ND*SD, -1, V0, -1, V0);
    frame("mid", 13, 4, VD, -1, V0);
    do_reset();
    frame("zero", ND*SD, 3, VE, -1, V0);
    frame("show_e", ND*SD, 3, VF, -1, V0);
    frame("show_f", ND*SD, -1, V0, -1, V0);
    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
